// File: rtl/regs_wb_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   state_e   : controller states (arbitration / sequenced clear)
//   NREQ      : number of write requesters
//   LAST_REG  : highest register index zeroed by a software clear
//   ptr_after : round-robin pointer value following a one-hot grant
package regs_wb_arbiter_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int NREQ     = 3;
  localparam int LAST_REG = 31;

  // Next requester to get first look after a grant: (i+1) mod 3.
  function automatic logic [1:0] ptr_after(input logic [NREQ-1:0] grant);
    if (grant[0]) begin
      return 2'd1;
    end else if (grant[1]) begin
      return 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/regs_wb_arbiter_rr_pick.sv
// Combinational 3-way round-robin selector.
//   elig_i  : eligible requester mask
//   ptr_i   : requester index that gets first look
//   grant_o : one-hot grant (all zero when nothing is eligible)
module rr_pick
  import regs_wb_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] elig_i,
  input  logic [1:0]      ptr_i,
  output logic [NREQ-1:0] grant_o
);

  logic [2:0] slot;
  logic       found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    slot    = '0;
    // Walk the requesters starting at ptr, wrapping modulo 3.
    for (int k = 0; k < NREQ; k++) begin
      slot = {1'b0, ptr_i} + 3'(k);
      if (slot >= 3'd3) begin
        slot = slot - 3'd3;
      end
      if (!found && elig_i[slot[1:0]]) begin
        grant_o[slot[1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter with a sequenced software clear.
//   clk, rst          : clock, asynchronous active-high reset
//   req, addrN, dataN : write requests 0 (ALU), 1 (load), 2 (debug/IO)
//   ack               : one-cycle grant pulse per requester
//   freeze            : stalls grants and clear steps
//   clr_start         : start zeroing registers 1..31
//   clr_busy/clr_done : clear in progress / one-cycle completion pulse
//   L_S, Wt_addr/data : registered register-file write port
module regs_wb_arbiter
  import regs_wb_arbiter_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req,
  input  logic [AW-1:0]   addr0,
  input  logic [AW-1:0]   addr1,
  input  logic [AW-1:0]   addr2,
  input  logic [DW-1:0]   data0,
  input  logic [DW-1:0]   data1,
  input  logic [DW-1:0]   data2,
  output logic [2:0]      ack,
  input  logic            freeze,
  input  logic            clr_start,
  output logic            clr_busy,
  output logic            clr_done,
  output logic            L_S,
  output logic [AW-1:0]   Wt_addr,
  output logic [DW-1:0]   Wt_data
);

  state_e            state_q;
  logic [1:0]        ptr_q;
  logic [AW-1:0]     cnt_q;
  logic [NREQ-1:0]   ack_q;
  logic              busy_q;
  logic              done_q;
  logic              ls_q;
  logic [AW-1:0]     waddr_q;
  logic [DW-1:0]     wdata_q;

  logic [NREQ-1:0]   elig_d;
  logic [NREQ-1:0]   grant_d;
  logic [AW-1:0]     sel_addr_d;
  logic [DW-1:0]     sel_data_d;
  logic              last_write_d;

  // A requester being acked this cycle has not yet dropped its request.
  assign elig_d = req & ~ack_q;

  rr_pick u_pick (
    .elig_i  (elig_d),
    .ptr_i   (ptr_q),
    .grant_o (grant_d)
  );

  always_comb begin
    sel_addr_d = addr0;
    sel_data_d = data0;
    if (grant_d[1]) begin
      sel_addr_d = addr1;
      sel_data_d = data1;
    end else if (grant_d[2]) begin
      sel_addr_d = addr2;
      sel_data_d = data2;
    end
  end

  // The write to the last register is on the port right now.
  assign last_write_d = busy_q && ls_q && (waddr_q == AW'(LAST_REG));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ARB;
      ptr_q   <= 2'd0;
      cnt_q   <= AW'(1);
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ls_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ack_q  <= '0;
      ls_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_ARB: begin
          if (!freeze) begin
            if (clr_start) begin
              // The first zeroing write goes out together with clr_busy,
              // so the busy window covers exactly the 31 write cycles.
              state_q <= ST_CLEAR;
              busy_q  <= 1'b1;
              ls_q    <= 1'b1;
              waddr_q <= cnt_q;
              wdata_q <= '0;
              cnt_q   <= cnt_q + AW'(1);
            end else if (|grant_d) begin
              ack_q   <= grant_d;
              ls_q    <= (sel_addr_d != '0);
              waddr_q <= sel_addr_d;
              wdata_q <= sel_data_d;
              ptr_q   <= ptr_after(grant_d);
            end
          end
        end
        ST_CLEAR: begin
          if (last_write_d) begin
            state_q <= ST_ARB;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!freeze) begin
            ls_q    <= 1'b1;
            waddr_q <= cnt_q;
            wdata_q <= '0;
            cnt_q   <= (cnt_q == AW'(LAST_REG)) ? AW'(1) : cnt_q + AW'(1);
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign ack      = ack_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign L_S      = ls_q;
  assign Wt_addr  = waddr_q;
  assign Wt_data  = wdata_q;

endmodule
